// File: rtl/matmul_sched_pkg.sv
// Shared types for the matmul job scheduler: descriptor layout and FSM state encoding.
package matmul_sched_pkg;

    localparam int ADDR_W = 16;
    localparam int DIM_W  = 16;
    localparam int CNT_W  = 16;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_LAUNCH = 2'd1;
    localparam logic [1:0] ST_WAIT   = 2'd2;
    localparam logic [1:0] ST_ERROR  = 2'd3;

    typedef enum logic [1:0] {
        IDLE   = ST_IDLE,
        LAUNCH = ST_LAUNCH,
        WAIT   = ST_WAIT,
        ERROR  = ST_ERROR
    } sched_state_e;

    typedef struct packed {
        logic [ADDR_W-1:0] a_addr;
        logic [ADDR_W-1:0] b_addr;
        logic [ADDR_W-1:0] c_addr;
        logic [DIM_W-1:0]  m;
        logic [DIM_W-1:0]  n;
        logic [DIM_W-1:0]  p;
    } job_t;

    function automatic logic is_zero_dim(input job_t j);
        return (j.m == '0) || (j.n == '0) || (j.p == '0);
    endfunction

endpackage

// File: rtl/sched_desc_fifo.sv
// Descriptor queue: synchronous FIFO of job_t with flush; pointers carry an extra
// wrap bit so full and empty are distinguishable without a separate counter.
module sched_desc_fifo
    import matmul_sched_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           push_i,
    input  logic                           pop_i,
    input  logic                           flush_i,
    input  job_t                           wr_data_i,
    output job_t                           rd_data_o,
    output logic                           full_o,
    output logic                           empty_o,
    output logic [$clog2(DEPTH+1)-1:0]     count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wr_q, wr_d;
    logic [AW:0] rd_q, rd_d;
    job_t        mem_q [DEPTH];
    logic        do_push;
    logic        do_pop;

    assign empty_o   = (wr_q == rd_q);
    assign full_o    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign count_o   = wr_q - rd_q;
    assign rd_data_o = mem_q[rd_q[AW-1:0]];

    // A flush frees every slot, so a same-cycle push always lands as the sole entry.
    assign do_pop  = pop_i & ~empty_o & ~flush_i;
    assign do_push = push_i & (~full_o | do_pop | flush_i);

    always_comb begin
        wr_d = wr_q;
        rd_d = rd_q;
        if (flush_i) begin
            rd_d = wr_q;
        end else if (do_pop) begin
            rd_d = rd_q + 1'b1;
        end
        if (do_push) begin
            wr_d = wr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_q[AW-1:0]] <= wr_data_i;
        end
    end

endmodule

// File: rtl/matmul_job_scheduler.sv
// Job-queue front end for the systolic array: buffers descriptors, launches them one at
// a time, retires on a rising done edge, skips zero-dimension jobs, and watchdogs hangs.
//
// state  | meaning
// IDLE   | no job in flight; pops the queue head when one is present
// LAUNCH | descriptor registered, start_o high for this single cycle
// WAIT   | array running; waits for a rising operation_done_i or the watchdog
// ERROR  | watchdog expired; queue still accepts pushes, only flush_i recovers
module matmul_job_scheduler
    import matmul_sched_pkg::*;
#(
    parameter int QUEUE_DEPTH    = 4,
    parameter int ADDR_WIDTH     = 16,
    parameter int DIM_WIDTH      = 16,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                                clk,
    input  logic                                reset_n,
    input  logic                                job_valid_i,
    output logic                                job_ready_o,
    input  logic [ADDR_WIDTH-1:0]               job_a_addr_i,
    input  logic [ADDR_WIDTH-1:0]               job_b_addr_i,
    input  logic [ADDR_WIDTH-1:0]               job_c_addr_i,
    input  logic [DIM_WIDTH-1:0]                job_m_i,
    input  logic [DIM_WIDTH-1:0]                job_n_i,
    input  logic [DIM_WIDTH-1:0]                job_p_i,
    input  logic                                flush_i,
    output logic                                start_o,
    output logic [ADDR_WIDTH-1:0]               base_addr_a_o,
    output logic [ADDR_WIDTH-1:0]               base_addr_b_o,
    output logic [ADDR_WIDTH-1:0]               base_addr_c_o,
    output logic [DIM_WIDTH-1:0]                m_o,
    output logic [DIM_WIDTH-1:0]                n_o,
    output logic [DIM_WIDTH-1:0]                p_o,
    input  logic                                operation_done_i,
    output logic                                busy_o,
    output logic [$clog2(QUEUE_DEPTH+1)-1:0]    queue_count_o,
    output logic                                job_done_o,
    output logic [CNT_W-1:0]                    jobs_done_o,
    output logic                                skip_o,
    output logic                                error_o
);

    // Down-counter loaded with TIMEOUT_CYCLES-1 so it hits zero in the last allowed WAIT cycle.
    localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WD_W-1:0] WD_LOAD = WD_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    sched_state_e     state_q, state_d;
    job_t             desc_q, desc_d;
    job_t             push_job;
    job_t             head_job;
    logic [WD_W-1:0]  wd_q, wd_d;
    logic [CNT_W-1:0] jobs_q, jobs_d;
    logic             error_q, error_d;
    logic             job_done_q, job_done_d;
    logic             skip_q, skip_d;
    logic             done_q;
    logic             fifo_full;
    logic             fifo_empty;
    logic             pop;
    logic             done_rise;
    logic             timeout;

    assign push_job = {job_a_addr_i, job_b_addr_i, job_c_addr_i, job_m_i, job_n_i, job_p_i};

    assign pop         = (state_q == IDLE) & ~fifo_empty & ~flush_i;
    assign job_ready_o = ~fifo_full | pop | flush_i;
    assign done_rise   = operation_done_i & ~done_q;
    assign timeout     = (TIMEOUT_CYCLES != 0) && (wd_q == '0);

    sched_desc_fifo #(
        .DEPTH(QUEUE_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push_i    (job_valid_i & job_ready_o),
        .pop_i     (pop),
        .flush_i   (flush_i),
        .wr_data_i (push_job),
        .rd_data_o (head_job),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty),
        .count_o   (queue_count_o)
    );

    always_comb begin
        state_d    = state_q;
        desc_d     = desc_q;
        wd_d       = wd_q;
        jobs_d     = jobs_q;
        error_d    = error_q;
        job_done_d = 1'b0;
        skip_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (pop) begin
                    desc_d = head_job;
                    if (is_zero_dim(head_job)) begin
                        job_done_d = 1'b1;
                        skip_d     = 1'b1;
                        jobs_d     = jobs_q + 1'b1;
                    end else begin
                        state_d = LAUNCH;
                    end
                end
            end
            LAUNCH: begin
                wd_d    = WD_LOAD;
                state_d = WAIT;
            end
            WAIT: begin
                // A completion in the watchdog's final cycle still retires normally.
                if (done_rise) begin
                    job_done_d = 1'b1;
                    jobs_d     = jobs_q + 1'b1;
                    state_d    = IDLE;
                end else if (timeout) begin
                    error_d = 1'b1;
                    state_d = ERROR;
                end else if (wd_q != '0) begin
                    wd_d = wd_q - 1'b1;
                end
            end
            ERROR: begin
                if (flush_i) begin
                    error_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            desc_q     <= '0;
            wd_q       <= '0;
            jobs_q     <= '0;
            error_q    <= 1'b0;
            job_done_q <= 1'b0;
            skip_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            desc_q     <= desc_d;
            wd_q       <= wd_d;
            jobs_q     <= jobs_d;
            error_q    <= error_d;
            job_done_q <= job_done_d;
            skip_q     <= skip_d;
            done_q     <= operation_done_i;
        end
    end

    assign start_o       = (state_q == LAUNCH);
    assign busy_o        = (state_q != IDLE);
    assign base_addr_a_o = desc_q.a_addr;
    assign base_addr_b_o = desc_q.b_addr;
    assign base_addr_c_o = desc_q.c_addr;
    assign m_o           = desc_q.m;
    assign n_o           = desc_q.n;
    assign p_o           = desc_q.p;
    assign job_done_o    = job_done_q;
    assign jobs_done_o   = jobs_q;
    assign skip_o        = skip_q;
    assign error_o       = error_q;

endmodule

// File: tb/tb_matmul_job_scheduler.sv
// Self-checking bench for matmul_job_scheduler: vector table plus hand-written
// sequences, with a descriptor scoreboard checked on every launch or skip.
module tb_matmul_job_scheduler;
    import matmul_sched_pkg::*;

    localparam int TO = 30;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        job_valid_i = 1'b0;
    logic        job_ready_o;
    logic [15:0] job_a_addr_i = '0, job_b_addr_i = '0, job_c_addr_i = '0;
    logic [15:0] job_m_i = '0, job_n_i = '0, job_p_i = '0;
    logic        flush_i = 1'b0;
    logic        start_o;
    logic [15:0] base_addr_a_o, base_addr_b_o, base_addr_c_o;
    logic [15:0] m_o, n_o, p_o;
    logic        operation_done_i = 1'b0;
    logic        busy_o;
    logic [2:0]  queue_count_o;
    logic        job_done_o;
    logic [15:0] jobs_done_o;
    logic        skip_o;
    logic        error_o;

    matmul_job_scheduler #(
        .QUEUE_DEPTH(4), .ADDR_WIDTH(16), .DIM_WIDTH(16), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .job_valid_i(job_valid_i), .job_ready_o(job_ready_o),
        .job_a_addr_i(job_a_addr_i), .job_b_addr_i(job_b_addr_i), .job_c_addr_i(job_c_addr_i),
        .job_m_i(job_m_i), .job_n_i(job_n_i), .job_p_i(job_p_i),
        .flush_i(flush_i), .start_o(start_o),
        .base_addr_a_o(base_addr_a_o), .base_addr_b_o(base_addr_b_o), .base_addr_c_o(base_addr_c_o),
        .m_o(m_o), .n_o(n_o), .p_o(p_o),
        .operation_done_i(operation_done_i), .busy_o(busy_o),
        .queue_count_o(queue_count_o), .job_done_o(job_done_o),
        .jobs_done_o(jobs_done_o), .skip_o(skip_o), .error_o(error_o)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    int   exp_done = 0;
    job_t sb[$];
    logic start_prev = 1'b0;

    typedef struct {
        job_t j;
        logic exp_skip;
        int   exp_jobs;
    } vec_t;

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic job_t mk(input logic [15:0] a, b, c, m, n, p);
        job_t j;
        j.a_addr = a; j.b_addr = b; j.c_addr = c;
        j.m = m; j.n = n; j.p = p;
        return j;
    endfunction

    task automatic drive_job(input job_t j);
        job_a_addr_i = j.a_addr; job_b_addr_i = j.b_addr; job_c_addr_i = j.c_addr;
        job_m_i = j.m; job_n_i = j.n; job_p_i = j.p;
    endtask

    task automatic push(input job_t j);
        int n = 0;
        drive_job(j);
        job_valid_i = 1'b1;
        while (!job_ready_o && n < 200) begin
            tick();
            n++;
        end
        if (!job_ready_o) begin
            checks++;
            errors++;
            $display("FAIL push_ready_timeout: job_ready_o stayed 0 for %0d cycles", n);
        end else begin
            tick();
            sb.push_back(j);
        end
        job_valid_i = 1'b0;
    endtask

    task automatic wait_start();
        int n = 0;
        while (!start_o && n < 100) begin
            tick();
            n++;
        end
        chk("start_seen", start_o, 1);
    endtask

    // Called while in LAUNCH: enter WAIT, then give a clean rising done edge.
    task automatic finish_job();
        tick();
        operation_done_i = 1'b1;
        tick();
        operation_done_i = 1'b0;
        exp_done++;
        chk("job_done", job_done_o, 1);
        chk("jobs_done", jobs_done_o, exp_done);
    endtask

    task automatic chk_reset_state();
        chk("rst_ready", job_ready_o, 1);
        chk("rst_start", start_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_count", queue_count_o, 0);
        chk("rst_job_done", job_done_o, 0);
        chk("rst_jobs_done", jobs_done_o, 0);
        chk("rst_skip", skip_o, 0);
        chk("rst_error", error_o, 0);
        chk("rst_desc", {base_addr_a_o, base_addr_b_o, base_addr_c_o, m_o, n_o, p_o}, 0);
    endtask

    always @(negedge clk) begin
        if (reset_n) begin
            if (start_o) chk("start_one_cycle", start_prev, 0);
            if (start_o || skip_o) begin
                job_t e;
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_underflow: start=%0b skip=%0b with no job expected", start_o, skip_o);
                end else begin
                    e = sb.pop_front();
                    chk("desc_order", {base_addr_a_o, base_addr_b_o, base_addr_c_o, m_o, n_o, p_o}, e);
                    chk("skip_flag", skip_o, is_zero_dim(e));
                end
            end
        end
        start_prev = start_o;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "global timeout");
    end

    initial begin
        vec_t vt[6];
        job_t j;
        int   pulses;

        vt[0] = '{mk(16'h1111, 16'h2222, 16'h3333, 16'd1, 16'd1, 16'd1), 1'b0, 2};
        vt[1] = '{mk(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF), 1'b0, 3};
        vt[2] = '{mk(16'h0010, 16'h0020, 16'h0030, 16'd0, 16'd5, 16'd5), 1'b1, 4};
        vt[3] = '{mk(16'h0011, 16'h0021, 16'h0031, 16'd5, 16'd0, 16'd5), 1'b1, 5};
        vt[4] = '{mk(16'h0012, 16'h0022, 16'h0032, 16'd5, 16'd5, 16'd0), 1'b1, 6};
        vt[5] = '{mk(16'h0A0A, 16'h0B0B, 16'h0C0C, 16'd2, 16'd3, 16'd4), 1'b0, 7};

        tick();
        tick();
        chk_reset_state();
        reset_n = 1'b1;
        tick();

        // Single job: launch latency and completion.
        push(mk(16'h0100, 16'h0200, 16'h0300, 16'd4, 16'd4, 16'd4));
        chk("lat_t0_start", start_o, 0);
        chk("lat_t0_count", queue_count_o, 1);
        tick();
        chk("lat_t1_start", start_o, 1);
        chk("lat_t1_busy", busy_o, 1);
        tick();
        chk("lat_t2_start", start_o, 0);
        repeat (19) tick();
        operation_done_i = 1'b1;
        tick();
        operation_done_i = 1'b0;
        exp_done++;
        chk("single_job_done", job_done_o, 1);
        chk("single_jobs_done", jobs_done_o, 1);
        chk("single_busy", busy_o, 0);

        // Vector table: normal, extreme and zero-dimension descriptors.
        for (int i = 0; i < 6; i++) begin
            push(vt[i].j);
            tick();
            if (vt[i].exp_skip) begin
                exp_done++;
                chk("vec_skip", skip_o, 1);
                chk("vec_skip_done", job_done_o, 1);
                chk("vec_skip_no_start", start_o, 0);
                chk("vec_skip_busy", busy_o, 0);
            end else begin
                chk("vec_start", start_o, 1);
                finish_job();
                chk("vec_no_skip", skip_o, 0);
            end
            chk("vec_jobs_done", jobs_done_o, vt[i].exp_jobs);
        end

        // Back-to-back: fill the queue behind a busy job, stall a fifth push.
        push(mk(16'h1000, 16'h2000, 16'h3000, 16'd8, 16'd8, 16'd8));
        wait_start();
        tick();
        for (int i = 1; i <= 4; i++) begin
            push(mk(16'h1000 + 16'(i), 16'h2000 + 16'(i), 16'h3000 + 16'(i), 16'(i), 16'd3, 16'd2));
        end
        chk("b2b_count_full", queue_count_o, 4);
        chk("b2b_ready_full", job_ready_o, 0);
        j = mk(16'h1005, 16'h2005, 16'h3005, 16'd7, 16'd7, 16'd7);
        drive_job(j);
        job_valid_i = 1'b1;
        tick();
        tick();
        chk("b2b_stall_ready", job_ready_o, 0);
        chk("b2b_stall_count", queue_count_o, 4);
        operation_done_i = 1'b1;
        tick();
        operation_done_i = 1'b0;
        exp_done++;
        chk("b2b_first_done", job_done_o, 1);
        chk("pushpop_ready", job_ready_o, 1);
        tick();
        job_valid_i = 1'b0;
        sb.push_back(j);
        chk("pushpop_count", queue_count_o, 4);
        for (int i = 0; i < 5; i++) begin
            wait_start();
            finish_job();
        end
        chk("b2b_drained", queue_count_o, 0);

        // Done held high across the next launch is not a completion.
        push(mk(16'h4000, 16'h4100, 16'h4200, 16'd3, 16'd3, 16'd3));
        wait_start();
        tick();
        operation_done_i = 1'b1;
        tick();
        exp_done++;
        chk("stuck_first_done", job_done_o, 1);
        push(mk(16'h4001, 16'h4101, 16'h4201, 16'd6, 16'd6, 16'd6));
        wait_start();
        pulses = 0;
        repeat (8) begin
            tick();
            if (job_done_o) pulses++;
        end
        chk("stuck_no_retire", pulses, 0);
        chk("stuck_busy", busy_o, 1);
        operation_done_i = 1'b0;
        tick();
        operation_done_i = 1'b1;
        tick();
        operation_done_i = 1'b0;
        exp_done++;
        chk("stuck_retire", job_done_o, 1);
        chk("stuck_jobs_done", jobs_done_o, exp_done);

        // Done edge in the watchdog's final cycle wins over the timeout.
        push(mk(16'h5000, 16'h5100, 16'h5200, 16'd1, 16'd2, 16'd3));
        wait_start();
        repeat (TO) tick();
        operation_done_i = 1'b1;
        tick();
        operation_done_i = 1'b0;
        exp_done++;
        chk("tie_done", job_done_o, 1);
        chk("tie_error", error_o, 0);
        chk("tie_busy", busy_o, 0);

        // Watchdog timeout, pushes in ERROR, flush recovery.
        push(mk(16'h6000, 16'h6100, 16'h6200, 16'd9, 16'd9, 16'd9));
        wait_start();
        push(mk(16'h6001, 16'h6101, 16'h6201, 16'd1, 16'd1, 16'd1));
        push(mk(16'h6002, 16'h6102, 16'h6202, 16'd2, 16'd2, 16'd2));
        repeat (TO - 2) tick();
        chk("to_last_wait_error", error_o, 0);
        chk("to_last_wait_busy", busy_o, 1);
        tick();
        chk("to_error_set", error_o, 1);
        chk("to_queue_kept", queue_count_o, 2);
        push(mk(16'h6003, 16'h6103, 16'h6203, 16'd3, 16'd3, 16'd3));
        chk("err_push_count", queue_count_o, 3);
        repeat (3) tick();
        chk("err_no_start", start_o, 0);
        chk("err_busy", busy_o, 1);
        chk("err_sticky", error_o, 1);
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        sb.delete();
        chk("flush_count", queue_count_o, 0);
        chk("flush_error", error_o, 0);
        chk("flush_busy", busy_o, 0);
        tick();
        chk("flush_no_start", start_o, 0);

        // Flush plus push in WAIT: in-flight job survives, pushed job is the only one left.
        push(mk(16'h7000, 16'h7100, 16'h7200, 16'd4, 16'd5, 16'd6));
        wait_start();
        tick();
        push(mk(16'h7001, 16'h7101, 16'h7201, 16'd1, 16'd1, 16'd1));
        push(mk(16'h7002, 16'h7102, 16'h7202, 16'd2, 16'd2, 16'd2));
        chk("fp_pre_count", queue_count_o, 2);
        j = mk(16'h7003, 16'h7103, 16'h7203, 16'd3, 16'd3, 16'd3);
        drive_job(j);
        job_valid_i = 1'b1;
        flush_i = 1'b1;
        tick();
        job_valid_i = 1'b0;
        flush_i = 1'b0;
        sb.delete();
        sb.push_back(j);
        chk("fp_count", queue_count_o, 1);
        chk("fp_busy", busy_o, 1);
        operation_done_i = 1'b1;
        tick();
        operation_done_i = 1'b0;
        exp_done++;
        chk("fp_inflight_done", job_done_o, 1);
        wait_start();
        finish_job();

        // Reset while in WAIT with a full queue.
        push(mk(16'h8000, 16'h8100, 16'h8200, 16'd2, 16'd2, 16'd2));
        wait_start();
        tick();
        for (int i = 1; i <= 4; i++) begin
            push(mk(16'h8000 + 16'(i), 16'h8100, 16'h8200, 16'd1, 16'd1, 16'd1));
        end
        chk("rst_pre_count", queue_count_o, 4);
        reset_n = 1'b0;
        tick();
        sb.delete();
        exp_done = 0;
        chk_reset_state();
        reset_n = 1'b1;
        tick();
        tick();
        chk("post_rst_busy", busy_o, 0);
        chk("post_rst_start", start_o, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
